// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks: FSM states, 8N1 frame
// geometry and the oversampling clock divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_W     = $clog2(DATA_BITS);

  // Clocks per sample tick, floored, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int d;
    d = clk_hz / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase
// restarted by clear.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt <= '0;
    end else if (clear || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, deframes bytes at mid-bit
// and hands them to the consumer through a ready/ack handshake.
// state | meaning
// IDLE  | waiting for a high-to-low edge on rx_s
// START | counting to mid start bit; a high sample there is a glitch
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling stop bit; deliver byte or flag framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRXD,
  input  logic       iACK,
  output logic [7:0] oDATA,
  output logic       oREADY,
  output logic       oBUSY,
  output logic       oFRAME_ERR,
  output logic       oOVERRUN
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVS);
  localparam int SMP_W = $clog2(OVS);
  localparam logic [SMP_W-1:0] HALF_LAST = SMP_W'(OVS / 2 - 1);
  localparam logic [SMP_W-1:0] FULL_LAST = SMP_W'(OVS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta, rx_s, rx_prev;
  state_e               state_q, state_d;
  logic                 tick, tick_clr;
  logic [SMP_W-1:0]     smp_cnt, smp_last;
  logic                 smp_hit;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_ok, stop_bad;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= iRXD;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign smp_last = (state_q == START) ? HALF_LAST : FULL_LAST;
  assign smp_hit  = tick && (smp_cnt == smp_last);
  assign oBUSY    = (state_q != IDLE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Start needs an actual edge, so a held-low line cannot retrigger.
  always_comb begin
    state_d  = state_q;
    tick_clr = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (smp_hit) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (smp_hit && bit_idx == LAST_BIT) state_d = STOP;
      end
      STOP: begin
        if (smp_hit) begin
          state_d  = IDLE;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      smp_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state_q == IDLE || smp_hit) smp_cnt <= '0;
      else if (tick)                  smp_cnt <= smp_cnt + 1'b1;
      if (state_q == START) begin
        bit_idx <= '0;
      end else if (state_q == DATA && smp_hit) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 1'b1;
      end
    end
  end

  // A completing byte takes priority over a same-cycle acknowledge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDATA      <= '0;
      oREADY     <= 1'b0;
      oFRAME_ERR <= 1'b0;
      oOVERRUN   <= 1'b0;
    end else begin
      oFRAME_ERR <= stop_bad;
      if (stop_ok) begin
        oREADY <= 1'b1;
        if (oREADY && !iACK) begin
          oOVERRUN <= 1'b1;
        end else begin
          oDATA    <= shift;
          oOVERRUN <= 1'b0;
        end
      end else if (iACK) begin
        oREADY   <= 1'b0;
        oOVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (DIV=1).
module tb_uart_rx;

  localparam int CLK_HZ   = 1600;
  localparam int BAUD     = 100;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] data;
  logic       ready, busy, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int   ready_rise = 0;
  int   fe_cnt     = 0;
  int   fe_run     = 0;
  int   fe_max     = 0;
  logic ready_prev = 1'b0;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iRXD      (rxd),
    .iACK      (ack),
    .oDATA     (data),
    .oREADY    (ready),
    .oBUSY     (busy),
    .oFRAME_ERR(frame_err),
    .oOVERRUN  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ready_prev <= ready;
    if (ready && !ready_prev) ready_rise <= ready_rise + 1;
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_run <= fe_run + 1;
      if (fe_run + 1 > fe_max) fe_max <= fe_run + 1;
    end else begin
      fe_run <= 0;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    bit busy_seen;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rxd = i[0];
      @(negedge clk);
    end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rxd   = 1'b1;
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy_seen); end
  endtask

  task automatic test_good_byte();
    int t, t_busy, fe0;
    fe0 = fe_cnt;
    t = 0;
    t_busy = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!ready && t < 200) begin
          @(negedge clk);
          t++;
          if (busy && t_busy < 0) t_busy = t;
        end
      end
    join
    n_checks++; if (t_busy < 1 || t_busy > 3) begin n_fail++; $display("FAIL good_busy_latency got=%0d exp=1..3", t_busy); end
    n_checks++; if (t < 150 || t > 160) begin n_fail++; $display("FAIL good_ready_latency got=%0d exp=150..160", t); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL good_data got=%h exp=a5", data); end
    n_checks++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL good_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
    pulse_ack();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL good_ack_ready got=%b exp=0", ready); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL good_ack_data got=%h exp=a5", data); end
  endtask

  task automatic test_glitch();
    int fe0, rr0;
    fe0 = fe_cnt;
    rr0 = ready_rise;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    n_checks++; if (ready !== 1'b0 || ready_rise !== rr0) begin n_fail++; $display("FAIL glitch_ready got=%b/%0d exp=0/%0d", ready, ready_rise, rr0); end
    n_checks++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL glitch_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
  endtask

  task automatic test_frame_error();
    int fe0;
    bit busy_seen;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    n_checks++; if (fe_cnt !== fe0 + 1) begin n_fail++; $display("FAIL ferr_pulses got=%0d exp=%0d", fe_cnt, fe0 + 1); end
    n_checks++; if (fe_max !== 1) begin n_fail++; $display("FAIL ferr_width got=%0d exp=1", fe_max); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ferr_ready got=%b exp=0", ready); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data got=%h exp=a5", data); end
    busy_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL break_busy got=%b exp=0", busy_seen); end
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || fe_cnt !== fe0 + 1) begin n_fail++; $display("FAIL break_release got=%b/%0d exp=0/%0d", busy, fe_cnt, fe0 + 1); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL ovr_data got=%h exp=11", data); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ovr_ready got=%b exp=1", ready); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    pulse_ack();
    n_checks++; if (ready !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack got=%b/%b exp=0/0", ready, overrun); end
    send_frame(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (data !== 8'h33) begin n_fail++; $display("FAIL ovr_next_data got=%h exp=33", data); end
    n_checks++; if (ready !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_next_flags got=%b/%b exp=1/0", ready, overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0, rr0;
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BIT_CLKS + 8) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (data !== 8'h00 || ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got=%h/%b/%b exp=00/0/0", data, ready, busy); end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    fe0 = fe_cnt;
    rr0 = ready_rise;
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (ready_rise !== rr0 + 1) begin n_fail++; $display("FAIL midrst_ready_count got=%0d exp=%0d", ready_rise, rr0 + 1); end
    n_checks++; if (data !== 8'h5A) begin n_fail++; $display("FAIL midrst_data got=%h exp=5a", data); end
    n_checks++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL midrst_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    pulse_ack();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
